// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: shares one synchronous-read data-memory port between
// master 0 (CPU load/store, fixed priority) and master 1 (e.g. UART DMA).
// An anti-starvation counter lets master 1 win after MAX_WAIT denied cycles,
// and a one-deep response pipeline steers read data back to the requester.
// Optional bus locking is built when the macro ARB_LOCK_EN is defined;
// without it the lock inputs are ignored and arbitration is purely
// starvation check, then master 0, then master 1.
module data_bus_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;
    logic       rsp_v;
    logic       rsp_id;
    logic       starved;

    assign starved = m1_req && (wait_cnt == MAX_WAIT_C);

`ifdef ARB_LOCK_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } lock_state_t;

    lock_state_t state;

    // Grant selection: a lock owner has exclusive use of the bus, otherwise
    // a starved master 1 beats master 0, which beats master 1.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!reset) begin
            m0_gnt = 1'b0;
            m1_gnt = 1'b0;
        end else if (state == OWN0) begin
            m0_gnt = m0_req;
        end else if (state == OWN1) begin
            m1_gnt = m1_req;
        end else if (starved) begin
            m1_gnt = 1'b1;
        end else if (m0_req) begin
            m0_gnt = 1'b1;
        end else if (m1_req) begin
            m1_gnt = 1'b1;
        end
    end

    // Lock FSM: an accepted access with lock set claims the bus, and the
    // owner's next accepted access with lock clear hands it back.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_gnt && m0_lock) begin
                        state <= OWN0;
                    end else if (m1_gnt && m1_lock) begin
                        state <= OWN1;
                    end
                end
                OWN0: begin
                    if (m0_gnt && !m0_lock) begin
                        state <= IDLE;
                    end
                end
                OWN1: begin
                    if (m1_gnt && !m1_lock) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    logic unused_lock;

    assign unused_lock = m0_lock ^ m1_lock;

    // Grant selection: a starved master 1 beats master 0, which beats master 1.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!reset) begin
            m0_gnt = 1'b0;
            m1_gnt = 1'b0;
        end else if (starved) begin
            m1_gnt = 1'b1;
        end else if (m0_req) begin
            m0_gnt = 1'b1;
        end else if (m1_req) begin
            m1_gnt = 1'b1;
        end
    end
`endif

    // Memory port mux: the granted master drives the port, idle port is all zero.
    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (m0_gnt) begin
            mem_rd    = !m0_wr;
            mem_wr    = m0_wr;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end else if (m1_gnt) begin
            mem_rd    = !m1_wr;
            mem_wr    = m1_wr;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end
    end

    // Starvation counter: counts master 1's consecutive denied cycles,
    // saturating, and restarts whenever master 1 is served or stops asking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= 4'd0;
        end else if (!m1_req || m1_gnt) begin
            wait_cnt <= 4'd0;
        end else if (wait_cnt < MAX_WAIT_C) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    // Response tag: remembers which master issued the read accepted last cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_v  <= 1'b0;
            rsp_id <= 1'b0;
        end else begin
            rsp_v <= mem_rd;
            if (mem_rd) begin
                rsp_id <= m1_gnt;
            end
        end
    end

    assign m0_rvalid = rsp_v && !rsp_id;
    assign m1_rvalid = rsp_v && rsp_id;
    assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule
